mod6_count_monitor: RTL and testbench
=====================================

MOD6_COUNT_MONITOR -- requirements
Module: mod6_count_monitor

Interface
REQ-001 The block SHALL have parameter TENS_MOD, default 10, giving the modulus of the wrap (tens) counter; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state advances on the rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: tracking enable.
REQ-005 The block SHALL have port cnt_in, input, 3 bits: the mod-6 ripple-counter outputs {qc,qb,qa}, asynchronous to clk.
REQ-006 The block SHALL have port cnt_q, output, 3 bits: the validated count.
REQ-007 The block SHALL have port locked, output, 1 bit: high while in state TRACK.
REQ-008 The block SHALL have port step, output, 1 bit: one-cycle pulse on each legal +1 transition.
REQ-009 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on each 5->0 transition.
REQ-010 The block SHALL have port tens, output, 4 bits: count of wraps modulo TENS_MOD.
REQ-011 The block SHALL have port tc, output, 1 bit: one-cycle pulse when tens goes from TENS_MOD-1 to 0.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal code or an illegal transition.
REQ-013 The block SHALL have port err_cnt, output, 8 bits: error count (see Configuration).

Function
REQ-014 cnt_in SHALL pass a 3-stage register chain s1->s2->s3; a sample SHALL be "stable" when s2==s3, and stable value v = s2.
REQ-015 A stable input change SHALL appear on cnt_q and pulses at the 4th rising edge after cnt_in settles.
REQ-016 Codes held for less than 2 clk cycles SHALL be rejected, including the transient 6 produced by the counter's clear.
REQ-017 FSM states SHALL be IDLE, TRACK and FAULT.
REQ-018 IDLE, stable v<=5: cnt_q=v, go to TRACK, no step/wrap/err.
REQ-019 IDLE, stable v>5: err pulse, go to FAULT.
REQ-020 TRACK, stable v==cnt_q: no action.
REQ-021 TRACK, cnt_q<5 and v==cnt_q+1: cnt_q=v, step pulse.
REQ-022 TRACK, cnt_q==5 and v==0: cnt_q=0; step and wrap pulse in the same cycle; tens increments modulo TENS_MOD; tc pulses in the same cycle as the increment from TENS_MOD-1 to 0.
REQ-023 TRACK, any other stable v: err pulse, cnt_q holds, go to FAULT.
REQ-024 FAULT: ignore all stable values except v==0, which SHALL set cnt_q=0 and enter TRACK without a step pulse.
REQ-025 en low SHALL force IDLE each cycle: cnt_q and tens hold, pulses stay 0, and the sync chain keeps running.
REQ-026 en rising SHALL resynchronise via IDLE and never report an err for the gap.
REQ-027 step, wrap, tc and err SHALL each be exactly one cycle wide, registered, and glitch-free.

Reset
REQ-028 While clr is high, s1..s3=0, cnt_q=0, tens=0, err_cnt=0, state=IDLE, and all pulses and locked SHALL be 0, independent of clk.
REQ-029 After clr deasserts mid-operation, the first stable value SHALL be handled per REQ-018/019 with no pulses for prior history.

Configuration
REQ-030 With macro MOD6_MON_ERRCNT_EN defined, err_cnt SHALL increment on each err pulse and saturate at 255; it is cleared only by clr.
REQ-031 Without MOD6_MON_ERRCNT_EN, err_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Reset, hold cnt_in=0, en=1 -> locked=1 at edge 4 after clr falls, cnt_q=0, no pulses.
REQ-033 Drive 0,1,2,3,4,5,0, each held 8 cycles -> 6 step pulses, 1 wrap pulse, tens=1, err=0.
REQ-034 Perform 10 full cycles with TENS_MOD=10 -> tc pulses once, coincident with wrap, and tens returns to 0.
REQ-035 Insert a 1-cycle 6 glitch between 5 and 0 -> no err, and wrap pulses; then hold a code of 3 after 1 -> err pulse, locked=0, recovery to TRACK only when 0 is held.
REQ-036 With the macro defined, force 300 errors -> err_cnt=255; without the macro -> err_cnt=0. Toggle en low at cnt_q=2 and drive 4 -> on en high, no err and cnt_q=4.

Source files
------------

// File: rtl/mod6_count_monitor_if.sv
// rtl/mod6_count_monitor_if.sv - enable, ripple-count input and monitor outputs of mod6_count_monitor
// The monitor itself uses the slave modport; whatever drives en/cnt_in uses master.
interface mod6_count_monitor_if;
  logic       en;
  logic [2:0] cnt_in;
  logic [2:0] cnt_q;
  logic       locked;
  logic       step;
  logic       wrap;
  logic [3:0] tens;
  logic       tc;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output en, cnt_in,
    input  cnt_q, locked, step, wrap, tens, tc, err, err_cnt
  );

  modport slave (
    input  en, cnt_in,
    output cnt_q, locked, step, wrap, tens, tc, err, err_cnt
  );
endinterface

// File: rtl/mod6_count_monitor.sv
// rtl/mod6_count_monitor.sv - synchronises and validates a mod-6 ripple counter, counts wraps and errors
// Optional saturating error counter: define MOD6_MON_ERRCNT_EN.
module mod6_count_monitor #(
  parameter int TENS_MOD = 10
) (
  input  logic                    clk,
  input  logic                    clr,
  mod6_count_monitor_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [3:0] TENS_LAST = 4'(TENS_MOD - 1);
  localparam logic [2:0] CODE_MAX  = 3'd5;

  state_t     state, state_n;
  logic [2:0] s1, s2, s3;
  logic [2:0] fill;
  logic       stable;
  logic [2:0] v;

  logic [2:0] cnt_q, cnt_n;
  logic [3:0] tens, tens_n;
  logic       step, step_n;
  logic       wrap, wrap_n;
  logic       tc, tc_n;
  logic       err, err_n;

  // fill tracks how far real samples have propagated, so the all-zero reset
  // contents of the chain are never mistaken for a stable input.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1   <= 3'd0;
      s2   <= 3'd0;
      s3   <= 3'd0;
      fill <= 3'd0;
    end else begin
      s1   <= bus.cnt_in;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  assign v      = s2;
  assign stable = fill[2] && (s2 == s3);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    tens_n  = tens;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    tc_n    = 1'b0;
    err_n   = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
    end else if (stable) begin
      case (state)
        IDLE: begin
          if (v <= CODE_MAX) begin
            cnt_n   = v;
            state_n = TRACK;
          end else begin
            err_n   = 1'b1;
            state_n = FAULT;
          end
        end
        TRACK: begin
          if (v == cnt_q) begin
            state_n = TRACK;
          end else if ((cnt_q < CODE_MAX) && (v == cnt_q + 3'd1)) begin
            cnt_n  = v;
            step_n = 1'b1;
          end else if ((cnt_q == CODE_MAX) && (v == 3'd0)) begin
            cnt_n  = 3'd0;
            step_n = 1'b1;
            wrap_n = 1'b1;
            if (tens == TENS_LAST) begin
              tens_n = 4'd0;
              tc_n   = 1'b1;
            end else begin
              tens_n = tens + 4'd1;
            end
          end else begin
            err_n   = 1'b1;
            state_n = FAULT;
          end
        end
        FAULT: begin
          // Only a settled zero is a trustworthy point to resume counting from.
          if (v == 3'd0) begin
            cnt_n   = 3'd0;
            state_n = TRACK;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= 3'd0;
      tens  <= 4'd0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      tc    <= 1'b0;
      err   <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      tens  <= tens_n;
      step  <= step_n;
      wrap  <= wrap_n;
      tc    <= tc_n;
      err   <= err_n;
    end
  end

`ifdef MOD6_MON_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      err_cnt <= 8'd0;
    else if (err_n && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  assign bus.err_cnt = err_cnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.cnt_q  = cnt_q;
  assign bus.locked = (state == TRACK);
  assign bus.step   = step;
  assign bus.wrap   = wrap;
  assign bus.tens   = tens;
  assign bus.tc     = tc;
  assign bus.err    = err;

endmodule

// File: tb/tb_mod6_count_monitor.sv
// tb/tb_mod6_count_monitor.sv - directed self-checking bench for mod6_count_monitor
module tb_mod6_count_monitor;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  int n_step, n_wrap, n_tc, n_err, n_tcwrap;
  int b_step, b_wrap, b_tc, b_err, b_tcwrap;
  int exp_errcnt;

  mod6_count_monitor_if bus ();

  mod6_count_monitor #(.TENS_MOD(10)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_step = 0; n_wrap = 0; n_tc = 0; n_err = 0; n_tcwrap = 0;
  end

  always @(negedge clk) begin
    if (bus.step === 1'b1) n_step++;
    if (bus.wrap === 1'b1) n_wrap++;
    if (bus.tc === 1'b1) n_tc++;
    if (bus.err === 1'b1) n_err++;
    if (bus.tc === 1'b1 && bus.wrap === 1'b1) n_tcwrap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] val, input int n);
    bus.cnt_in = val;
    tick(n);
  endtask

  task automatic snap();
    b_step = n_step; b_wrap = n_wrap; b_tc = n_tc; b_err = n_err; b_tcwrap = n_tcwrap;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr      = 1'b1;
    bus.en     = 1'b1;
    bus.cnt_in = 3'd0;
    tick(3);

    check("rst_cnt_q", 32'(bus.cnt_q), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_tens", 32'(bus.tens), 0);
    check("rst_err_cnt", 32'(bus.err_cnt), 0);
    check("rst_pulses", 32'({bus.step, bus.wrap, bus.tc, bus.err}), 0);

    // lock-up latency from reset release
    clr = 1'b0;
    snap();
    tick(3);
    check("lock_edge3", 32'(bus.locked), 0);
    tick(1);
    check("lock_edge4", 32'(bus.locked), 1);
    check("lock_cnt_q", 32'(bus.cnt_q), 0);
    check("lock_no_pulse", 32'(n_step + n_err + n_wrap - b_step - b_err - b_wrap), 0);
    tick(4);

    // one full count with 8-cycle holds, verifying 4-edge latency on the first step
    snap();
    bus.cnt_in = 3'd1;
    tick(3);
    check("lat_edge3", 32'(bus.cnt_q), 0);
    tick(1);
    check("lat_edge4", 32'(bus.cnt_q), 1);
    tick(4);
    hold(3'd2, 8);
    hold(3'd3, 8);
    hold(3'd4, 8);
    hold(3'd5, 8);
    hold(3'd0, 8);
    check("cyc1_steps", 32'(n_step - b_step), 6);
    check("cyc1_wraps", 32'(n_wrap - b_wrap), 1);
    check("cyc1_tens", 32'(bus.tens), 1);
    check("cyc1_err", 32'(n_err - b_err), 0);

    // nine more wraps bring tens from 1 through 9 back to 0
    snap();
    for (int c = 0; c < 9; c++) begin
      for (int k = 1; k <= 5; k++) hold(3'(k), 3);
      hold(3'd0, 3);
    end
    tick(6);
    check("dec_wraps", 32'(n_wrap - b_wrap), 9);
    check("dec_tc", 32'(n_tc - b_tc), 1);
    check("dec_tc_with_wrap", 32'(n_tcwrap - b_tcwrap), 1);
    check("dec_tens", 32'(bus.tens), 0);

    // transient 6 from the counter clear must be filtered
    snap();
    for (int k = 1; k <= 5; k++) hold(3'(k), 3);
    hold(3'd6, 1);
    hold(3'd0, 8);
    check("glitch_err", 32'(n_err - b_err), 0);
    check("glitch_wrap", 32'(n_wrap - b_wrap), 1);
    check("glitch_tens", 32'(bus.tens), 1);
    check("glitch_cnt_q", 32'(bus.cnt_q), 0);

    // illegal 1->3 jump, then recovery only through a held 0
    snap();
    hold(3'd1, 4);
    check("jump_pre", 32'(bus.cnt_q), 1);
    hold(3'd3, 8);
    check("jump_err", 32'(n_err - b_err), 1);
    check("jump_locked", 32'(bus.locked), 0);
    check("jump_hold_cnt", 32'(bus.cnt_q), 1);
    hold(3'd2, 8);
    check("fault_ignore", 32'(bus.locked), 0);
    hold(3'd0, 1);
    hold(3'd2, 6);
    check("fault_short0", 32'(bus.locked), 0);
    snap();
    hold(3'd0, 8);
    check("recover_locked", 32'(bus.locked), 1);
    check("recover_cnt_q", 32'(bus.cnt_q), 0);
    check("recover_no_step", 32'(n_step - b_step), 0);
`ifdef MOD6_MON_ERRCNT_EN
    exp_errcnt = 1;
`else
    exp_errcnt = 0;
`endif
    check("errcnt_one", 32'(bus.err_cnt), 32'(exp_errcnt));

    // enable gap: count jumps 2->4 while disabled, resynchronised without error
    hold(3'd1, 3);
    hold(3'd2, 8);
    check("gap_pre", 32'(bus.cnt_q), 2);
    snap();
    bus.en = 1'b0;
    hold(3'd4, 8);
    check("gap_hold_cnt", 32'(bus.cnt_q), 2);
    check("gap_idle", 32'(bus.locked), 0);
    check("gap_tens", 32'(bus.tens), 1);
    bus.en = 1'b1;
    tick(8);
    check("gap_cnt_q", 32'(bus.cnt_q), 4);
    check("gap_locked", 32'(bus.locked), 1);
    check("gap_err", 32'(n_err - b_err), 0);
    check("gap_step", 32'(n_step - b_step), 0);

    // 300 errors: illegal code 7 re-reported each time en re-enters IDLE
    bus.en = 1'b0;
    hold(3'd7, 4);
    snap();
    for (int i = 0; i < 300; i++) begin
      bus.en = 1'b1;
      tick(1);
      bus.en = 1'b0;
      tick(1);
    end
    tick(2);
    check("sat_err_pulses", 32'(n_err - b_err), 300);
`ifdef MOD6_MON_ERRCNT_EN
    exp_errcnt = 255;
`else
    exp_errcnt = 0;
`endif
    check("sat_err_cnt", 32'(bus.err_cnt), 32'(exp_errcnt));

    // asynchronous clear mid-cycle, then clean restart on a held 3
    bus.en     = 1'b1;
    bus.cnt_in = 3'd3;
    #3;
    clr = 1'b1;
    #1;
    check("aclr_cnt_q", 32'(bus.cnt_q), 0);
    check("aclr_tens", 32'(bus.tens), 0);
    check("aclr_err_cnt", 32'(bus.err_cnt), 0);
    check("aclr_locked", 32'(bus.locked), 0);
    tick(2);
    clr = 1'b0;
    snap();
    tick(3);
    check("restart_edge3", 32'(bus.locked), 0);
    tick(1);
    check("restart_locked", 32'(bus.locked), 1);
    check("restart_cnt_q", 32'(bus.cnt_q), 3);
    tick(2);
    check("restart_quiet", 32'(n_step + n_err + n_wrap - b_step - b_err - b_wrap), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
